// File: rtl/iir_coef_ctrl_if.sv
// Bundle of signals between the coefficient controller, its configuration
// master, the upstream sample source, the IIR datapath and the sample sink.
// The slave modport is the controller's view; the master modport is the view
// of everything around it.
interface iir_coef_ctrl_if #(
  parameter int unsigned DW = 9
);
  // configuration port
  logic          cfg_we;
  logic [2:0]    cfg_addr;
  logic [DW-1:0] cfg_data;
  logic          cfg_commit;
  logic          cfg_busy;
  // upstream sample stream
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  // IIR datapath side
  logic [DW-1:0] iir_din;
  logic          iir_vin;
  logic [DW-1:0] iir_a1;
  logic [DW-1:0] iir_a2;
  logic [DW-1:0] iir_b0;
  logic [DW-1:0] iir_b1;
  logic [DW-1:0] iir_b2;
  logic [DW-1:0] iir_dout;
  logic          iir_vout;
  // filtered output to sink
  logic [DW-1:0] dout;
  logic          vout;

  modport master (
    output cfg_we, cfg_addr, cfg_data, cfg_commit, in_valid, in_data,
           iir_dout, iir_vout,
    input  cfg_busy, in_ready, iir_din, iir_vin,
           iir_a1, iir_a2, iir_b0, iir_b1, iir_b2, dout, vout
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, cfg_commit, in_valid, in_data,
           iir_dout, iir_vout,
    output cfg_busy, in_ready, iir_din, iir_vin,
           iir_a1, iir_a2, iir_b0, iir_b1, iir_b2, dout, vout
  );
endinterface

// File: rtl/iir_coef_ctrl.sv
// Coefficient bank controller in front of an IIR biquad. Coefficients are
// written into a shadow bank; a commit stalls the input, lets in-flight
// samples drain, swaps shadow into active in one edge, then pushes zero
// samples through the filter. Results belonging to those zero samples are
// masked so the sink only ever sees outputs of real samples.
module iir_coef_ctrl #(
  parameter int unsigned DW        = 9,
  parameter int unsigned DRAIN_CYC = 4,
  parameter int unsigned FLUSH_LEN = 2
) (
  input logic            clk,
  input logic            rst_n,
  iir_coef_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, HOLD, SWAP, FLUSH} state_t;

  // Shared phase counter for HOLD and FLUSH; suppress counter only needs to
  // cover the flush samples of one sequence plus headroom.
  localparam int unsigned CW = $clog2(DRAIN_CYC + FLUSH_LEN + 1);
  localparam int unsigned SW = $clog2(FLUSH_LEN + 1) + 1;

  state_t             state, state_nx;
  logic [CW-1:0]      cnt, cnt_nx;
  logic               pending, pending_nx;
  logic [4:0][DW-1:0] shadow;   // index = cfg_addr: a1, a2, b0, b1, b2
  logic [4:0][DW-1:0] active;
  logic [SW-1:0]      suppress;
  logic               flush_issue;
  logic               drop_one;
  logic               pass_out;
  logic               vout_q;
  logic [DW-1:0]      dout_q;

  // State, phase counter and pending flag registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      pending <= pending_nx;
    end
  end

  // Next-state logic: RUN -> HOLD (drain) -> SWAP -> FLUSH -> RUN.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    pending_nx = pending | bus.cfg_commit;
    unique case (state)
      RUN: begin
        if (pending || bus.cfg_commit) begin
          state_nx = HOLD;
          cnt_nx   = '0;
        end
      end
      HOLD: begin
        if (cnt == CW'(DRAIN_CYC - 1)) begin
          state_nx = SWAP;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      SWAP: begin
        // The request being served retires here; a commit in this very
        // cycle starts a fresh request.
        state_nx   = FLUSH;
        pending_nx = bus.cfg_commit;
      end
      FLUSH: begin
        if (cnt == CW'(FLUSH_LEN - 1)) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = RUN;
    endcase
  end

  // Stream gating toward the filter: pass-through in RUN, zeros in FLUSH.
  // NOTE: these outputs are combinational, so rst_n gates them directly to hold them low while reset is asserted.
  always_comb begin
    bus.in_ready = 1'b0;
    bus.iir_vin  = 1'b0;
    bus.iir_din  = '0;
    if (rst_n) begin
      unique case (state)
        RUN: begin
          bus.in_ready = 1'b1;
          bus.iir_vin  = bus.in_valid;
          bus.iir_din  = bus.in_data;
        end
        FLUSH:   bus.iir_vin = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.cfg_busy = (state != RUN) || pending;

  // Shadow bank writes (any state) and the atomic shadow-to-active swap.
  // NOTE: the banks are plain registers, reset to zero so the filter starts from a known bank and an aborted swap leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (bus.cfg_we && (bus.cfg_addr < 3'd5)) begin
        shadow[bus.cfg_addr] <= bus.cfg_data;
      end
      if (state == SWAP) begin
        active <= shadow;
      end
    end
  end

  assign bus.iir_a1 = active[0];
  assign bus.iir_a2 = active[1];
  assign bus.iir_b0 = active[2];
  assign bus.iir_b1 = active[3];
  assign bus.iir_b2 = active[4];

  assign flush_issue = (state == FLUSH);
  assign drop_one    = bus.iir_vout && (suppress != '0);
  assign pass_out    = bus.iir_vout && (suppress == '0);

  // Count flush samples still inside the filter; each of their results is swallowed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      suppress <= '0;
    end else if (flush_issue && !drop_one) begin
      suppress <= suppress + SW'(1);
    end else if (!flush_issue && drop_one) begin
      suppress <= suppress - SW'(1);
    end
  end

  // Registered output toward the sink; dout holds its last real value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vout_q <= 1'b0;
      dout_q <= '0;
    end else begin
      vout_q <= pass_out;
      if (pass_out) begin
        dout_q <= bus.iir_dout;
      end
    end
  end

  assign bus.vout = vout_q;
  assign bus.dout = dout_q;

endmodule

// File: tb/tb_iir_coef_ctrl.sv
// Bench for iir_coef_ctrl. A small biquad with 3-cycle latency stands in for
// the IIR datapath. The reference model treats a commit as a fixed-length
// blocked window on a cycle timeline and runs its own biquad over the ideal
// sample sequence (accepted samples, plus zeros at each bank change).
module tb_iir_coef_ctrl;
  localparam int DW        = 9;
  localparam int DRAIN_CYC = 4;
  localparam int FLUSH_LEN = 2;
  localparam int SEQ       = DRAIN_CYC + 1 + FLUSH_LEN;
  localparam int LAT       = 4;   // accept cycle -> vout cycle (3 filter + 1 register)

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  iir_coef_ctrl_if #(.DW(DW)) u ();

  iir_coef_ctrl #(.DW(DW), .DRAIN_CYC(DRAIN_CYC), .FLUSH_LEN(FLUSH_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sx(input logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  // Biquad with Q6 coefficients (0x040 = 1.0); c = {b2, b1, b0, a2, a1}.
  function automatic logic [DW-1:0] biq(input logic [DW-1:0] x0, x1, x2, y1, y2,
                                        input logic [4:0][DW-1:0] c);
    int acc;
    acc = sx(c[2]) * sx(x0) + sx(c[3]) * sx(x1) + sx(c[4]) * sx(x2)
        - sx(c[0]) * sx(y1) - sx(c[1]) * sx(y2);
    acc = acc >>> 6;
    return acc[DW-1:0];
  endfunction

  // ---------------- stand-in IIR datapath ----------------
  logic [DW-1:0]      s_x1, s_x2, s_y1, s_y2;
  logic [2:0]         s_vp;
  logic [2:0][DW-1:0] s_dp;
  wire  [DW-1:0]      s_y = biq(u.iir_din, s_x1, s_x2, s_y1, s_y2,
                                {u.iir_b2, u.iir_b1, u.iir_b0, u.iir_a2, u.iir_a1});

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_x1 <= '0; s_x2 <= '0; s_y1 <= '0; s_y2 <= '0;
      s_vp <= '0; s_dp <= '0;
    end else begin
      s_vp <= {s_vp[1:0], u.iir_vin};
      s_dp <= {s_dp[1:0], s_y};
      if (u.iir_vin) begin
        s_x2 <= s_x1; s_x1 <= u.iir_din;
        s_y2 <= s_y1; s_y1 <= s_y;
      end
    end
  end
  assign u.iir_vout = s_vp[2];
  assign u.iir_dout = s_dp[2];

  // ---------------- reference model ----------------
  typedef struct { int due; logic [DW-1:0] val; } exp_t;
  exp_t               outq[$];
  logic [4:0][DW-1:0] sh, act;
  logic [DW-1:0]      fx1, fx2, fy1, fy2;
  int                 busy_left, cyc;
  bit                 re_arm, chk_en, exp_v;

  task automatic mdl_reset();
    sh = '0; act = '0;
    fx1 = '0; fx2 = '0; fy1 = '0; fy2 = '0;
    busy_left = 0; re_arm = 1'b0; cyc = 0;
    outq.delete();
  endtask

  task automatic model_step(input logic [DW-1:0] x, input bit real_sample);
    logic [DW-1:0] y;
    y = biq(x, fx1, fx2, fy1, fy2, act);
    if (real_sample) outq.push_back('{cyc + LAT, y});
    fx2 = fx1; fx1 = x; fy2 = fy1; fy1 = y;
  endtask

  // Per-cycle comparison against the model, then model advance.
  always @(negedge clk) begin
    if (chk_en) begin
      cyc++;
      check("cfg_busy", u.cfg_busy, (busy_left != 0) || re_arm);
      check("in_ready", u.in_ready, busy_left == 0);
      if (busy_left == 0) begin
        check("iir_vin", u.iir_vin, u.in_valid);
        if (u.in_valid) check("iir_din", u.iir_din, u.in_data);
      end else if (busy_left <= FLUSH_LEN) begin
        check("flush_vin", u.iir_vin, 1);
        check("flush_din", u.iir_din, 0);
      end else begin
        check("hold_vin", u.iir_vin, 0);
      end
      check("coefs", {u.iir_b2, u.iir_b1, u.iir_b0, u.iir_a2, u.iir_a1}, act);
      exp_v = (outq.size() > 0) && (outq[0].due == cyc);
      check("vout", u.vout, exp_v);
      if (exp_v && u.vout) check("dout", u.dout, outq[0].val);
      while (outq.size() > 0 && outq[0].due <= cyc) outq.delete(0);

      if (busy_left == 0) begin
        if (u.in_valid) model_step(u.in_data, 1'b1);
        if (re_arm || u.cfg_commit) begin
          busy_left = SEQ;
          re_arm    = 1'b0;
        end
      end else begin
        if (u.cfg_commit && busy_left <= FLUSH_LEN + 1) re_arm = 1'b1;
        if (busy_left == FLUSH_LEN + 1) begin
          act = sh;
          for (int i = 0; i < FLUSH_LEN; i++) model_step('0, 1'b0);
        end
        busy_left--;
      end
      if (u.cfg_we && u.cfg_addr < 3'd5) sh[u.cfg_addr] = u.cfg_data;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    u.cfg_we = 1'b0; u.cfg_addr = '0; u.cfg_data = '0; u.cfg_commit = 1'b0;
    u.in_valid = 1'b0; u.in_data = '0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [DW-1:0] d);
    u.cfg_we = 1'b1; u.cfg_addr = a; u.cfg_data = d;
    tick();
    u.cfg_we = 1'b0;
  endtask

  task automatic commit();
    u.cfg_commit = 1'b1;
    tick();
    u.cfg_commit = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_in_ready"}, u.in_ready, 0);
    check({tag, "_busy"}, u.cfg_busy, 0);
    check({tag, "_iir_vin"}, u.iir_vin, 0);
    check({tag, "_iir_din"}, u.iir_din, 0);
    check({tag, "_vout"}, u.vout, 0);
    check({tag, "_dout"}, u.dout, 0);
    check({tag, "_coefs"}, {u.iir_b2, u.iir_b1, u.iir_b0, u.iir_a2, u.iir_a1}, 0);
  endtask

  task automatic release_reset();
    set_idle();
    mdl_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_en = 1'b1;
  endtask

  logic [4:0][DW-1:0] pin_c;
  logic [4:0][DW-1:0] ramp_bank;
  logic [DW-1:0]      ramp;
  int                 acc_cnt, vcnt, bcnt, rcnt, fcnt;

  initial begin
    chk_en = 1'b0;
    set_idle();
    mdl_reset();

    // Pin the reference biquad with hand-computed values.
    pin_c = '0; pin_c[2] = 9'h040;
    check("pin_b0_unity", biq(9'd5, '0, '0, '0, '0, pin_c), 9'd5);
    pin_c[3] = 9'h020;
    check("pin_b0_b1", biq(9'd3, 9'd2, '0, '0, '0, pin_c), 9'd4);
    pin_c = '0; pin_c[0] = 9'h040;
    check("pin_a1_feedback", biq('0, '0, '0, 9'd10, '0, pin_c), 9'h1F6);

    // Reset values while reset is held, with live-looking inputs.
    #3;
    u.in_valid = 1'b1; u.in_data = 9'h0AA;
    rst_n = 1'b0;
    #2;
    reset_checks("reset");
    #20;
    release_reset();

    // Shadow write alone does not touch the active bank.
    wr(3'd2, 9'h040);
    for (int n = 0; n < 5; n++) begin
      u.in_valid = 1'b1; u.in_data = DW'($urandom);
      @(negedge clk);
      check("nocommit_b0", u.iir_b0, 0);
      check("nocommit_ready", u.in_ready, 1);
      tick();
    end
    u.in_valid = 1'b0;
    repeat (6) tick();

    // Idle commit: 7 busy cycles, 2 zero flush samples, no output pulse.
    commit();
    bcnt = 0; vcnt = 0; fcnt = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (u.cfg_busy) bcnt++;
      if (u.vout) vcnt++;
      if (u.iir_vin && u.iir_din == '0) fcnt++;
      tick();
    end
    check("idle_busy_cycles", bcnt, 7);
    check("idle_flush_samples", fcnt, 2);
    check("idle_vout_pulses", vcnt, 0);
    check("idle_b0", u.iir_b0, 9'h040);

    // Ramp stream with a commit mid-stream.
    ramp_bank = {9'h008, 9'h010, 9'h020, 9'h000, 9'h010};
    for (int i = 0; i < 5; i++) wr(3'(i), ramp_bank[i]);
    repeat (8) tick();
    ramp = 9'd1; acc_cnt = 0; vcnt = 0;
    for (int n = 0; n < 40; n++) begin
      u.cfg_commit = (n == 15);
      u.in_valid = 1'b1; u.in_data = ramp;
      @(negedge clk);
      if (n == 15) check("ready_at_commit", u.in_ready, 1);
      if (n == 16) check("ready_after_commit", u.in_ready, 0);
      if (u.in_ready) begin acc_cnt++; ramp = ramp + 9'd1; end
      if (u.vout) vcnt++;
      tick();
    end
    u.in_valid = 1'b0; u.cfg_commit = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (u.vout) vcnt++;
      tick();
    end
    check("ramp_accepted", acc_cnt, 40 - SEQ);
    check("ramp_vout_count", vcnt, acc_cnt);

    // Commit again in HOLD (merged) and in SWAP (one more sequence).
    commit();
    bcnt = 0; rcnt = 0; fcnt = 0;
    for (int k = 1; k <= 25; k++) begin
      u.cfg_commit = (k == 2) || (k == 5);
      @(negedge clk);
      if (u.cfg_busy) bcnt++;
      if (u.cfg_busy && u.in_ready) rcnt++;
      if (u.iir_vin) fcnt++;
      tick();
    end
    u.cfg_commit = 1'b0;
    check("rearm_busy_cycles", bcnt, 2 * SEQ + 1);
    check("rearm_ready_cycles", rcnt, 1);
    check("rearm_flush_samples", fcnt, 2 * FLUSH_LEN);

    // Writes to unused addresses change nothing.
    wr(3'd6, 9'h1FF);
    wr(3'd7, 9'h1FF);
    commit();
    repeat (10) tick();
    check("unused_addr_coefs", {u.iir_b2, u.iir_b1, u.iir_b0, u.iir_a2, u.iir_a1}, ramp_bank);

    // Randomized traffic: samples, shadow writes and commits at any time.
    for (int n = 0; n < 1500; n++) begin
      u.in_valid   = ($urandom_range(0, 3) != 0);
      u.in_data    = DW'($urandom);
      u.cfg_we     = ($urandom_range(0, 7) == 0);
      u.cfg_addr   = 3'($urandom_range(0, 7));
      u.cfg_data   = DW'($urandom_range(0, 127)) - 9'd48;
      u.cfg_commit = ($urandom_range(0, 29) == 0);
      tick();
    end
    set_idle();
    repeat (12) tick();
    check("random_drain", outq.size(), 0);

    // Reset in the middle of FLUSH aborts everything.
    commit();
    repeat (5) tick();
    u.in_valid = 1'b1; u.in_data = 9'h055;
    chk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks("flush_reset");
    #20;
    release_reset();
    @(negedge clk);
    check("post_reset_ready", u.in_ready, 1);
    check("post_reset_busy", u.cfg_busy, 0);
    tick();
    for (int n = 0; n < 10; n++) begin
      u.in_valid = 1'b1; u.in_data = DW'($urandom);
      tick();
    end
    set_idle();
    repeat (8) tick();
    check("final_drain", outq.size(), 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/iir_coef_ctrl.md
Name: iir_coef_ctrl

Overview:
Configuration and sequencing controller placed in front of the IIR biquad datapath (din, a1, a2, b0, b1, b2, vin, dout, vout). It holds shadow and active coefficient banks and gates the upstream sample stream. On commit it updates coefficients atomically between samples: stall input, drain in-flight samples, swap banks, flush filter memory with zero samples, then resume. Outputs produced by flush samples are suppressed, so the downstream sink sees only real results.

Parameters:
DW, 9, sample and coefficient width
DRAIN_CYC, 4, cycles the input is held stalled before the swap; must be at least the IIR vin-to-vout latency
FLUSH_LEN, 2, zero samples injected after the swap; must be at least the filter state depth

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  shadow coefficient write strobe
cfg_addr  in  3  0=a1, 1=a2, 2=b0, 3=b1, 4=b2; 5-7 are ignored
cfg_data  in  DW  coefficient value
cfg_commit  in  1  one-cycle pulse requesting the shadow-to-active update
cfg_busy  out  1  high whenever state is not RUN or a commit is pending
in_valid  in  1  upstream sample valid
in_ready  out  1  upstream sample accepted when high together with in_valid
in_data  in  DW  upstream sample
iir_din  out  DW  to IIR din
iir_vin  out  1  to IIR vin
iir_a1, iir_a2, iir_b0, iir_b1, iir_b2  out  DW each  active coefficients to IIR
iir_dout  in  DW  from IIR dout
iir_vout  in  1  from IIR vout
dout  out  DW  filtered sample to sink
vout  out  1  filtered sample valid

Behaviour:
- Reset (async, rst_n=0):
  - state=RUN; pending=0.
  - Shadow and active banks are 0.
  - Counters are 0; cfg_busy=0; in_ready=0 during reset.
  - iir_vin=0, iir_din=0, vout=0, dout=0.
- Reset asserted mid-sequence aborts immediately to these values. No partial swap is retained.
- Shadow writes: cfg_we=1 with addr 0-4 writes cfg_data into the shadow register on that edge, in any state. Addresses 5-7 have no effect.
- Commit capture: cfg_commit sets pending. A commit while pending=1 or state!=RUN is merged into the single pending request; it is never lost and never queued twice.
- State machine, states RUN, HOLD, SWAP, FLUSH:
  - RUN:
    - in_ready=1.
    - iir_din=in_data and iir_vin=in_valid, combinational pass-through.
    - If pending=1 (including a commit arriving this cycle), go to HOLD on the next edge. in_ready=0 from that next cycle on. A sample handshaken in the commit cycle is accepted and uses the old coefficients.
  - HOLD:
    - in_ready=0, iir_vin=0.
    - Count DRAIN_CYC cycles, then go to SWAP.
  - SWAP (1 cycle):
    - The active bank loads from the shadow bank; pending clears.
    - A cfg_we in this cycle updates the shadow only. The active bank takes the pre-write shadow value.
    - A cfg_commit in this cycle sets pending again.
    - Next state is FLUSH.
  - FLUSH:
    - in_ready=0, iir_din=0, iir_vin=1 for exactly FLUSH_LEN consecutive cycles, then back to RUN.
    - If pending is set again, RUN moves to HOLD after one RUN cycle in which in_ready=1.
- Output masking:
  - suppress counter: +1 per flush sample issued, -1 per iir_vout while nonzero. Simultaneous +1 and -1 leave it unchanged.
  - vout=iir_vout when suppress==0, else 0. dout=iir_dout when vout=1.
  - dout and vout are registered, adding 1 cycle of latency.
- iir_a* change only on the SWAP edge, never while a real sample is inside the filter.
- cfg_busy=1 in HOLD, SWAP and FLUSH, and in RUN while pending=1.
- The update sequence occupies DRAIN_CYC+1+FLUSH_LEN cycles, 7 with the defaults.

Test Plan:
- Reset then write addr 2=0x040 with no commit, stream 5 samples → iir_b0 stays 0 and in_ready stays 1 throughout.
- Write b0=0x040 and commit with the input idle → cfg_busy high for 7 cycles. iir_b0=0x040 from the SWAP edge. iir_vin=1 with iir_din=0 for 2 cycles. No vout pulse from the flush samples.
- Continuous in_valid=1 (ramp 1,2,3…) with a commit mid-stream → in_ready drops the cycle after the commit. No sample is lost or duplicated. The vout count equals the accepted-sample count, and the output sequence matches the golden IIR with the coefficient change at the correct sample index.
- Commit pulsed during HOLD, and again during SWAP → exactly one further update sequence follows the first, entered after one RUN cycle with in_ready=1.
- cfg_we addr 6 and addr 7 with data 0x1FF, then commit → all iir_a*/b* unchanged.
- rst_n pulsed low during FLUSH → all outputs return to reset values asynchronously, the active bank is 0, and state is RUN after release.
